// File: rtl/src_stream_tx.sv
// Buffer-to-stream transmitter: reads ss+1 words per batch from a 1-cycle-latency buffer
// into a 2-entry FIFO feeding a valid/ready stream. Optional macro SRC_TX_REPEAT_EN adds nb batch repeats.
module src_stream_tx #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] ss,
`ifdef SRC_TX_REPEAT_EN
  input  logic [3:0]    nb,
`endif
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          src_valid,
  output logic [DW-1:0] src_data,
  output logic          src_last,
  input  logic          src_ready,
  output logic [1:0]    state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] ss_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    bcnt;
  logic [3:0]    nb_q;
  logic          pend, pend_last, pend_fin;
  logic [1:0]    occ;
  logic [DW-1:0] h_data, t_data;
  logic          h_last, h_fin, t_last, t_fin;

  logic pop, push, addr_end, last_batch, space_ok, final_rd, fin_pop;

  // Stream handshake: a word moves when src_valid && src_ready; once src_valid is
  // high the word is held unchanged until accepted (abort drops it).
  assign pop        = (occ != 2'd0) && src_ready;
  assign push       = pend;
  assign addr_end   = (addr_q == ss_q);
  assign last_batch = (bcnt == nb_q);
  assign space_ok   = (({1'b0, occ} + {2'b00, pend}) - {2'b00, pop}) < 3'd2;
  assign rd_en      = (state == S_RUN) && !abort && space_ok;
  assign final_rd   = rd_en && addr_end && last_batch;
  assign fin_pop    = pop && h_fin;

  assign busy      = (state != S_IDLE);
  assign rd_addr   = addr_q;
  assign src_valid = (occ != 2'd0);
  assign src_data  = h_data;
  assign src_last  = h_last && src_valid;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      done <= (state == S_DRAIN) && fin_pop;
      case (state)
        S_IDLE:  if (start)    state <= S_RUN;
        S_RUN:   if (final_rd) state <= S_DRAIN;
        S_DRAIN: if (fin_pop)  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= '0;
      addr_q <= '0;
      bcnt   <= 4'd0;
    end else if ((state == S_IDLE) && start && !abort) begin
      ss_q   <= ss;
      addr_q <= '0;
      bcnt   <= 4'd0;
    end else if (rd_en) begin
      if (addr_end) begin
        addr_q <= '0;
        bcnt   <= bcnt + 4'd1;
      end else begin
        addr_q <= addr_q + AW'(1);
      end
    end
  end

`ifdef SRC_TX_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      nb_q <= 4'd0;
    else if ((state == S_IDLE) && start && !abort)
      nb_q <= nb;
  end
`else
  assign nb_q = 4'd0;
`endif

  // One read is in flight per cycle; its tags say where it sits in the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_last <= 1'b0;
      pend_fin  <= 1'b0;
    end else begin
      pend      <= rd_en;
      pend_last <= addr_end;
      pend_fin  <= final_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= 2'd0;
      h_data <= '0;
      h_last <= 1'b0;
      h_fin  <= 1'b0;
      t_data <= '0;
      t_last <= 1'b0;
      t_fin  <= 1'b0;
    end else if (abort) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            h_data <= rd_data;
            h_last <= pend_last;
            h_fin  <= pend_fin;
          end else begin
            t_data <= rd_data;
            t_last <= pend_last;
            t_fin  <= pend_fin;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          h_data <= t_data;
          h_last <= t_last;
          h_fin  <= t_fin;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            h_data <= rd_data;
            h_last <= pend_last;
            h_fin  <= pend_fin;
          end else begin
            h_data <= t_data;
            h_last <= t_last;
            h_fin  <= t_fin;
            t_data <= rd_data;
            t_last <= pend_last;
            t_fin  <= pend_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_src_stream_tx.sv
// Directed bench for src_stream_tx: buffer model, expected-word queue checked on
// every handshake, plus cycle-exact timing, stall-stability, abort and reset checks.
module tb_src_stream_tx;
  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [AW-1:0] ss;
`ifdef SRC_TX_REPEAT_EN
  logic [3:0]    nb;
`endif
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          src_valid, src_last, src_ready;
  logic [DW-1:0] src_data;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int outstanding = 0;
  logic [DW:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  src_stream_tx #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ss(ss),
`ifdef SRC_TX_REPEAT_EN
    .nb(nb),
`endif
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready), .state_dbg(state_dbg)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'h100 + {{(DW-AW){1'b0}}, a};
  endfunction

  always @(posedge clk) rd_data <= rd_en ? mem_word(rd_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every handshake pops and compares one expected word
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", src_valid, 1'b1);
        chk("hold_data", src_data, prev_data);
        chk("hold_last", src_last, prev_last);
      end
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1'b1, 1'b0);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("hs_data", src_data, e[DW-1:0]);
          chk("hs_last", src_last, e[DW]);
        end
      end
      if (rd_en) begin
        chk("rd_space", ((outstanding - int'(src_valid && src_ready)) < 2), 1'b1);
        chk("rd_when_busy", busy, 1'b1);
      end
      if (done) done_cnt++;
      outstanding = outstanding + int'(rd_en) - int'(src_valid && src_ready);
      if (abort) outstanding = 0;
      prev_stall = src_valid && !src_ready && !abort;
      prev_data  = src_data;
      prev_last  = src_last;
    end else begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_batch(input int ss_v, input int nb_v);
    for (int b = 0; b <= nb_v; b++)
      for (int i = 0; i <= ss_v; i++)
        exp_q.push_back({(i == ss_v), mem_word(AW'(i))});
  endtask

  task automatic start_xfer(input int ss_v, input int nb_v);
    start = 1'b1;
    ss    = AW'(ss_v);
`ifdef SRC_TX_REPEAT_EN
    nb    = 4'(nb_v);
`else
    if (nb_v != 0) $display("note: repeat count ignored in this build");
`endif
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit toggle);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      if (toggle) src_ready = ~src_ready;
      tick();
      n++;
    end
    @(negedge clk);
    chk("done_within_budget", (done_cnt > d0), 1'b1);
    src_ready = 1'b1;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rd_en"}, rd_en, 1'b0);
    chk({tag, "_rd_addr"}, rd_addr, '0);
    chk({tag, "_valid"}, src_valid, 1'b0);
    chk({tag, "_last"}, src_last, 1'b0);
    chk({tag, "_data"}, src_data, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ss = '0; src_ready = 1'b1;
`ifdef SRC_TX_REPEAT_EN
    nb = 4'd0;
`endif
    repeat (3) tick();
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("after_release");
    chk("reset_state", state_dbg, 2'd0);
    tick();

    // ss=3, ready high: exact cycle timing
    push_batch(3, 0);
    start_xfer(3, 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("t1_rd_en", rd_en, (c >= 1 && c <= 4));
      chk("t1_busy", busy, (c >= 1 && c <= 6));
      chk("t1_valid", src_valid, (c >= 3 && c <= 6));
      chk("t1_last", src_last, (c == 6));
      chk("t1_done", done, (c == 7));
      tick();
    end
    chk("t1_queue_empty", exp_q.size(), 0);

    // ss=7, ready toggling every cycle
    push_batch(7, 0);
    start_xfer(7, 0);
    run_until_done(80, 1'b1);
    chk("t2_queue_empty", exp_q.size(), 0);

    // ss=0: single word
    push_batch(0, 0);
    start_xfer(0, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("t3_valid", src_valid, (c == 3));
      chk("t3_last", src_last, (c == 3));
      chk("t3_done", done, (c == 4));
      tick();
    end
    chk("t3_queue_empty", exp_q.size(), 0);

    // ss=15, abort on the handshake of word 5
    for (int i = 0; i <= 5; i++) exp_q.push_back({1'b0, mem_word(AW'(i))});
    start_xfer(15, 0);
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("t4_valid_after_abort", src_valid, 1'b0);
    chk("t4_busy_after_abort", busy, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("t4_no_done", done, 1'b0);
      chk("t4_no_valid", src_valid, 1'b0);
      tick();
      @(negedge clk);
    end
    chk("t4_queue_empty", exp_q.size(), 0);
    tick();
    push_batch(1, 0);
    start_xfer(1, 0);
    run_until_done(20, 1'b0);
    chk("t4_restart_queue_empty", exp_q.size(), 0);

    // abort and start together: start dropped
    abort = 1'b1;
    start_xfer(5, 0);
    abort = 1'b0;
    @(negedge clk);
    chk("t5_busy", busy, 1'b0);
    chk("t5_rd_en", rd_en, 1'b0);
    tick();

    // repeated start during RUN is ignored
    push_batch(7, 0);
    start_xfer(7, 0);
    start = 1'b1; ss = AW'(2);
    tick();
    start = 1'b0;
    run_until_done(40, 1'b0);
    chk("t6_queue_empty", exp_q.size(), 0);
    chk("t6_idle", busy, 1'b0);

    // reset pulsed mid-transfer
    push_batch(15, 0);
    start_xfer(15, 0);
    repeat (6) tick();
    #1 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t7_no_resume_busy", busy, 1'b0);
      chk("t7_no_resume_valid", src_valid, 1'b0);
      chk("t7_no_resume_rd_en", rd_en, 1'b0);
      tick();
    end

`ifdef SRC_TX_REPEAT_EN
    // ss=2, nb=2: nine contiguous words, three lasts, one done
    push_batch(2, 2);
    start_xfer(2, 2);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      chk("t8_valid", src_valid, (c >= 3 && c <= 11));
      chk("t8_last", src_last, (c == 5 || c == 8 || c == 11));
      chk("t8_done", done, (c == 12));
      tick();
    end
    chk("t8_queue_empty", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/src_stream_tx.md
SRC_STREAM_TX -- requirements
Module: src_stream_tx

Interface
REQ-001 DW, 32, data width of the buffer and the stream.
REQ-002 AW, 12, buffer address width, equal to the batch length field width.
REQ-003 clk  in  1  single clock; all flops sample on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a transfer.
REQ-006 abort  in  1  synchronous cancel of the current transfer.
REQ-007 ss  in  AW  last word index of a batch (batch length ss+1), latched at start.
REQ-008 nb  in  4  batch repeat count minus one, latched at start (present only with SRC_TX_REPEAT_EN).
REQ-009 busy  out  1  transfer in progress.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rd_en  out  1  buffer read strobe.
REQ-012 rd_addr  out  AW  buffer read address.
REQ-013 rd_data  in  DW  buffer read data, valid exactly one cycle after rd_en.
REQ-014 src_valid  out  1  stream word valid.
REQ-015 src_data  out  DW  stream word.
REQ-016 src_last  out  1  marks word index ss of each batch.
REQ-017 src_ready  in  1  downstream accept; a word transfers when src_valid&src_ready.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN; reset state IDLE.
REQ-019 IDLE->RUN on start; start latches ss (and nb); rd_addr restarts at 0; start in RUN/DRAIN is ignored.
REQ-020 RUN->DRAIN after the cycle issuing the final read (addr ss, last batch).
REQ-021 DRAIN->IDLE on the handshake of the final src_last word; done pulses the following cycle.
REQ-022 busy is high in RUN and DRAIN and low otherwise.
REQ-023 2-entry output FIFO; rd_en is issued only while occupancy + in-flight reads - (pop this cycle) < 2.
REQ-024 Read data is written into the FIFO at the end of the cycle it arrives; src_valid/src_data/src_last are driven from the FIFO head register.
REQ-025 Latency: start sampled at edge 0 -> rd_en in cycle 1 -> rd_data in cycle 2 -> src_valid in cycle 3.
REQ-026 Throughput: with src_ready held high, one word per cycle with no bubbles, including across batch boundaries.
REQ-027 Once src_valid rises, src_valid, src_data and src_last hold stable until handshake (abort excepted).
REQ-028 src_ready deasserting: the in-flight read lands in entry 2; no read is issued while the FIFO is full; no data is lost or duplicated.
REQ-029 rd_addr increments by 1 per rd_en, wraps from ss to 0 at a batch boundary; arithmetic is modulo 2^AW.
REQ-030 ss=0: each batch is one word with src_last=1.
REQ-031 abort in any state: next cycle state IDLE, FIFO emptied, in-flight read discarded, src_valid=0, busy=0, no done pulse.
REQ-032 abort and start in the same cycle: abort wins; start is dropped.
REQ-033 rd_en is never asserted in IDLE.

Reset
REQ-034 rst_n low asynchronously forces IDLE, FIFO empty, rd_addr=0, batch counter=0.
REQ-035 All outputs are 0 during reset and in the first cycle after release.
REQ-036 Reset release mid-stream does not resume the prior transfer.

Configuration
REQ-037 Macro SRC_TX_REPEAT_EN defined: nb port present; nb+1 batches are sent back-to-back, each ending with src_last; done follows the final batch only.
REQ-038 SRC_TX_REPEAT_EN undefined: nb port absent; exactly one batch per start.

Verification
REQ-039 ss=3, ready high, buffer[i]=0x100+i -> src_valid cycles 3..6, data 0x100..0x103, src_last in cycle 6 only, done in cycle 7.
REQ-040 ss=7, ready toggling 1/0 each cycle -> all 8 words delivered in order exactly once, data stable while stalled, rd_en never issued with FIFO full.
REQ-041 ss=0 -> a single word with src_valid and src_last high together, then done.
REQ-042 ss=15, abort on the handshake of word 5 -> src_valid=0 and busy=0 next cycle, no done; a new start with ss=1 sends buffer[0],buffer[1].
REQ-043 SRC_TX_REPEAT_EN defined, ss=2, nb=2, ready high -> 9 contiguous words, src_last on words 2, 5 and 8, a single done.
REQ-044 start repeated during RUN, and rst_n pulsed low mid-transfer -> repeated start has no effect; rst_n clears all outputs immediately.
